// File: rtl/ascon_round_ctrl_spa.sv
// Round controller for the SPA-protected Ascon permutation: fixed 14-cycle call latency for p^12/p^6 (and p^8).
// Optional feature: define ASCON_P8_EN to accept mode 2'b10 as p^8; otherwise it is rejected like the reserved mode.
module ascon_round_ctrl_spa (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cst_sel,
    output logic       cst_en,
    output logic       round_en,
    output logic       last_round,
    output logic [3:0] rnd_idx
);

    // state | meaning
    // IDLE  | waiting for start; mode checked here
    // LOAD  | constant generator loads 0xF0, round counter cleared
    // SKIP  | generator advances past the constants of omitted rounds
    // RUN   | one permutation round per cycle, generator advances
    // DONE  | one-cycle completion pulse, generator holds
    typedef enum logic [2:0] {IDLE, LOAD, SKIP, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] skip, skip_nxt;
    logic       err_q, err_nxt;
    logic       mode_ok;
    logic [3:0] mode_skip;

    always_comb begin
        mode_ok   = 1'b0;
        mode_skip = 4'd0;
        case (mode)
            2'b00: begin
                mode_ok   = 1'b1;
                mode_skip = 4'd0;
            end
            2'b01: begin
                mode_ok   = 1'b1;
                mode_skip = 4'd6;
            end
`ifdef ASCON_P8_EN
            2'b10: begin
                mode_ok   = 1'b1;
                mode_skip = 4'd4;
            end
`endif
            default: begin
                mode_ok   = 1'b0;
                mode_skip = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            skip  <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            skip  <= skip_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        skip_nxt  = skip;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode_ok) begin
                        state_nxt = LOAD;
                        skip_nxt  = mode_skip;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                cnt_nxt   = 4'd0;
                state_nxt = (skip != 4'd0) ? SKIP : RUN;
            end
            SKIP: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == skip - 4'd1)
                    state_nxt = RUN;
            end
            RUN: begin
                // counter leaves 11 only through the state exit, so 12..15 never appear
                if (cnt == 4'd11) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        err        = err_q;
        cst_sel    = (state == LOAD);
        cst_en     = (state == LOAD) || (state == SKIP) || (state == RUN);
        round_en   = (state == RUN);
        last_round = (state == RUN) && (cnt == 4'd11);
        rnd_idx    = ((state == SKIP) || (state == RUN)) ? cnt : 4'd0;
    end

endmodule

// File: tb/tb_ascon_round_ctrl_spa.sv
// Bench for ascon_round_ctrl_spa: call-schedule reference model plus a model of the round-constant generator.
// Expectations for mode 2'b10 follow ASCON_P8_EN as the design does.
module tb_ascon_round_ctrl_spa;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic       busy, done, err, cst_sel, cst_en, round_en, last_round;
    logic [3:0] rnd_idx;

    ascon_round_ctrl_spa dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cst_sel    (cst_sel),
        .cst_en     (cst_en),
        .round_en   (round_en),
        .last_round (last_round),
        .rnd_idx    (rnd_idx)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    // reference: d = cycles since the accepting edge (1 = LOAD ... 14 = DONE)
    bit         in_call;
    int         d;
    int         skip_m;
    bit         err_exp;
    logic [7:0] gen;

    function automatic int skip_of(input logic [1:0] m);
        case (m)
            2'd0: return 0;
            2'd1: return 6;
            2'd2: begin
`ifdef ASCON_P8_EN
                return 4;
`else
                return -1;
`endif
            end
            default: return -1;
        endcase
    endfunction

    // {busy, done, err, cst_sel, cst_en, round_en, last_round, rnd_idx}
    function automatic logic [10:0] exp_vec();
        logic [10:0] v;
        v = '0;
        if (!in_call) begin
            v[8] = err_exp;
        end else if (d == 1) begin
            v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        end else if (d <= 1 + skip_m) begin
            v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(d - 2)};
        end else if (d <= 13) begin
            v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (d == 13), 4'(d - 2)};
        end else begin
            v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_now();
        int i;
        chk("outputs", {21'd0, busy, done, err, cst_sel, cst_en, round_en, last_round, rnd_idx},
            {21'd0, exp_vec()});
        if (in_call && d >= 2 + skip_m && d <= 13) begin
            i = d - 2;
            chk("round_const", {24'd0, gen}, {24'd0, 8'(((15 - i) << 4) | i)});
        end
        if (in_call && d == 14)
            chk("gen_after_done", {24'd0, gen}, 32'h3C);
    endtask

    // called at a falling edge; drives inputs for the next rising edge, then checks
    task automatic cycle(input bit s, input logic [1:0] m, input bit a);
        logic sel_c, en_c;
        int   sk;
        start = s;
        mode  = m;
        abort = a;
        sel_c = cst_sel;
        en_c  = cst_en;
        @(posedge clk);
        if (sel_c)
            gen = 8'hF0;
        else if (en_c)
            gen = {gen[7:4] - 4'd1, gen[3:0] + 4'd1};
        if (in_call) begin
            err_exp = 1'b0;
            if (a || d == 14)
                in_call = 1'b0;
            else
                d++;
        end else begin
            err_exp = 1'b0;
            if (s) begin
                sk = skip_of(m);
                if (sk < 0) begin
                    err_exp = 1'b1;
                end else begin
                    in_call = 1'b1;
                    d       = 1;
                    skip_m  = sk;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_now();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cycle(1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 2'd0;
        abort   = 1'b0;
        gen     = 8'hxx;
        in_call = 1'b0;
        err_exp = 1'b0;
        d       = 0;
        skip_m  = 0;
        repeat (2) @(negedge clk);
        check_now();
        rst = 1'b0;
        idle(2);

        cycle(1'b1, 2'd0, 1'b0);   // p^12
        idle(16);
        cycle(1'b1, 2'd1, 1'b0);   // p^6
        idle(16);
        cycle(1'b1, 2'd3, 1'b0);   // reserved mode
        idle(3);
        cycle(1'b1, 2'd2, 1'b0);   // p^8 or rejected
        idle(16);

        cycle(1'b1, 2'd0, 1'b0);   // start while busy is ignored
        idle(4);
        cycle(1'b1, 2'd1, 1'b0);
        idle(12);

        cycle(1'b1, 2'd0, 1'b0);   // abort at T+7, restart at T+9
        idle(6);
        cycle(1'b0, 2'd0, 1'b1);
        idle(1);
        cycle(1'b1, 2'd0, 1'b0);
        idle(16);

        cycle(1'b1, 2'd3, 1'b1);   // abort in IDLE has no effect on err
        cycle(1'b1, 2'd1, 1'b1);   // nor on acceptance
        idle(16);

        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 24) == 0);

        idle(16);
        cycle(1'b1, 2'd0, 1'b0);   // async reset mid-RUN
        idle(5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {21'd0, busy, done, err, cst_sel, cst_en, round_en, last_round, rnd_idx}, 32'd0);
        in_call = 1'b0;
        err_exp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_now();
        rst = 1'b0;
        idle(1);
        cycle(1'b1, 2'd0, 1'b0);
        idle(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascon_round_ctrl_spa.md
# ascon_round_ctrl_spa

Round controller for the SPA-protected Ascon permutation datapath. It sequences one permutation call (p^12, p^8 or p^6) and drives the select/enable pair of the round-constant generator, which holds an 8-bit register, loads 0xF0 on select and steps upper nibble −1 / lower nibble +1 per enable. It also provides the per-round update enable for the permutation state register. Every call has a fixed 14-cycle latency regardless of round count, so timing carries no information about the mode.

## Interface
- No parameters.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one permutation call; sampled only in IDLE.
- mode  in  2  00 = p^12, 01 = p^6, 10 = p^8 (macro-gated), 11 = reserved; sampled with start.
- abort  in  1  synchronous abort; any non-IDLE state → IDLE on next edge.
- busy  out  1  high in LOAD, SKIP, RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse after a rejected start.
- cst_sel  out  1  to constant generator select; high only in LOAD.
- cst_en  out  1  to constant generator enable; high in LOAD, SKIP and RUN.
- round_en  out  1  permutation state update enable; high only in RUN.
- last_round  out  1  high in the final RUN cycle.
- rnd_idx  out  4  absolute round index i (0..11) of the constant currently in the generator, during SKIP and RUN.

## Operation
- States: IDLE, LOAD, SKIP, RUN, DONE. All outputs are decoded from registered state and counter (Moore); none is combinational from inputs.
- IDLE + start + legal mode → LOAD. Latch skip = 12 − N (0, 4 or 6) and N (12, 8 or 6).
- IDLE + start + illegal mode → remain IDLE, err = 1 for next cycle.
- LOAD (1 cycle): cst_sel = cst_en = 1. Generator holds 0xF0 next cycle. rnd_idx cleared to 0. → SKIP if skip > 0, else RUN.
- SKIP (skip cycles): cst_en = 1, round_en = 0. Discards constants 0..skip−1. rnd_idx increments each cycle. → RUN.
- RUN (N cycles): round_en = cst_en = 1. The datapath consumes constant ((15−i)<<4)|i this cycle while the generator advances. rnd_idx increments. last_round = 1 when rnd_idx = 11. → DONE after the cycle with rnd_idx = 11.
- DONE (1 cycle): done = 1, cst_en = 0, so the generator holds 0x3C. → IDLE.
- Internal 4-bit counter wraps from 11 only via state exit; values 12..15 never occur.
- start while busy: ignored, no err.
- abort in the same cycle as DONE: done still pulses, then IDLE.
- abort in IDLE: no effect.
- abort has priority over all other non-IDLE transitions.
- The generator has no reset, so its contents are undefined until LOAD. This block never asserts round_en before LOAD has completed.

## Timing
- Reset values: state IDLE, busy = done = err = cst_sel = cst_en = round_en = last_round = 0, rnd_idx = 0.
- start accepted at edge T:
  - LOAD in cycle T+1.
  - SKIP from T+2 to T+1+skip.
  - RUN ends at T+13.
  - done high at cycle T+14.
  - Next start accepted at edge T+15.
- First RUN cycle: p^12 at T+2 (constant 0xF0), p^8 at T+6 (0xB4), p^6 at T+8 (0x96).
- Total cst_en-high cycles per call = 13: 1 load + 12 advances.
- Reset asserted mid-call: outputs cleared immediately (asynchronous), no done; the generator keeps a stale value.

## Configuration
- ASCON_P8_EN defined: mode 10 is legal p^8 (skip 4, run 8).
- ASCON_P8_EN undefined: mode 10 is treated like 11, i.e. rejected with an err pulse; only p^12 and p^6 are supported.

## Test plan
- p^12: start with mode 00 at T → cst_sel only at T+1; round_en T+2..T+13; bench model of the generator shows 0xF0, 0xE1 … 0x4B over those cycles; done at T+14; generator = 0x3C afterwards.
- p^6: start with mode 01 → round_en T+8..T+13 with constants 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B; last_round at T+13; done at T+14.
- Mode 11 (and 10 without macro) → err pulse at T+1, busy stays 0, no cst_en. With ASCON_P8_EN, mode 10 → first RUN constant 0xB4 at T+6, done at T+14.
- start at T+5 of a running call → ignored; done still at T+14; no err.
- abort at T+7 of p^12 → busy = 0 at T+8, no done pulse, no further round_en; a new start at T+9 completes with done at T+23.
- rst asserted asynchronously mid-RUN → all outputs 0 before the next edge; after release, start completes normally with first RUN constant 0xF0.
